// File: rtl/phase_sequencer_if.sv
// Control bundle between the phase sequencer, the memory bus handshake and the datapath.
// The master modport is the sequencer side. The slave modport is the memory/datapath side.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [7:0]       ir_op;
  logic             mem_ready;
  logic [2:0]       phase;
  logic             ir_we;
  logic             mem_re;
  logic             mem_we;
  logic             rf_re;
  logic             alu_en;
  logic             flag_we;
  logic             rf_we;
  logic             pc_we;
  logic             pc_sel;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, ir_op, mem_ready,
    output phase, ir_we, mem_re, mem_we, rf_re, alu_en, flag_we, rf_we,
           pc_we, pc_sel, halted, illegal, bus_err, instr_count
  );

  modport slave (
    output start, ir_op, mem_ready,
    input  phase, ir_we, mem_re, mem_we, rf_re, alu_en, flag_we, rf_we,
           pc_we, pc_sel, halted, illegal, bus_err, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase (f/r/x/m/w) instruction sequencer with halt, illegal-opcode and memory-timeout handling.
// Strobes are decoded from the state register and the live mem_ready/ir_op inputs, so a reset drops them at once.
module phase_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_F    = 3'd0,
    ST_R    = 3'd1,
    ST_X    = 3'd2,
    ST_M    = 3'd3,
    ST_W    = 3'd4,
    ST_IDLE = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OC_LD   = 3'd0,
    OC_ST   = 3'd1,
    OC_ALUW = 3'd2,
    OC_LIL  = 3'd3,
    OC_CMP  = 3'd4,
    OC_JMP  = 3'd5,
    OC_HLT  = 3'd6,
    OC_ILL  = 3'd7
  } opclass_t;

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic opclass_t decode_op(input logic [7:0] op);
    case (op)
      8'h8B:                                            decode_op = OC_LD;
      8'h89:                                            decode_op = OC_ST;
      8'h01, 8'h29, 8'h21, 8'h09, 8'h31, 8'h83, 8'hF7,
      8'hC1:                                            decode_op = OC_ALUW;
      8'h66:                                            decode_op = OC_LIL;
      8'h39:                                            decode_op = OC_CMP;
      8'h90:                                            decode_op = OC_JMP;
      8'hF4:                                            decode_op = OC_HLT;
      default:                                          decode_op = OC_ILL;
    endcase
  endfunction

  state_t           state_r;
  logic [TW-1:0]    tmo_r;
  logic             illegal_r;
  logic             bus_err_r;
  logic [CNT_W-1:0] count_r;

  opclass_t opclass_s;
  logic     ir_we_s, mem_re_s, mem_we_s, rf_re_s, alu_en_s;
  logic     flag_we_s, rf_we_s, pc_we_s, pc_sel_s;

  assign opclass_s = decode_op(bus.ir_op);

  // Strobe decode from the current phase and the live handshake/opcode inputs.
  always_comb begin
    ir_we_s   = 1'b0;
    mem_re_s  = 1'b0;
    mem_we_s  = 1'b0;
    rf_re_s   = 1'b0;
    alu_en_s  = 1'b0;
    flag_we_s = 1'b0;
    rf_we_s   = 1'b0;
    pc_we_s   = 1'b0;
    pc_sel_s  = 1'b0;
    case (state_r)
      ST_F: begin
        mem_re_s = 1'b1;
        ir_we_s  = bus.mem_ready;
      end
      ST_R: rf_re_s = 1'b1;
      ST_X: begin
        alu_en_s  = 1'b1;
        flag_we_s = (opclass_s == OC_ALUW) || (opclass_s == OC_CMP);
        pc_we_s   = (opclass_s == OC_CMP) || (opclass_s == OC_JMP);
        pc_sel_s  = (opclass_s == OC_JMP);
      end
      ST_M: begin
        mem_re_s = (opclass_s == OC_LD);
        mem_we_s = (opclass_s == OC_ST);
        pc_we_s  = (opclass_s == OC_ST) && bus.mem_ready;
      end
      ST_W: begin
        rf_we_s = 1'b1;
        pc_we_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase FSM with timeout counter, sticky error flags and the retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      tmo_r     <= {TW{1'b0}};
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
    end else begin
      if (pc_we_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          tmo_r <= {TW{1'b0}};
          if (bus.start) begin
            state_r <= ST_F;
          end
        end
        ST_F: begin
          if (bus.mem_ready) begin
            state_r <= ST_R;
            tmo_r   <= {TW{1'b0}};
          end else if (tmo_r == TMO_LAST) begin
            state_r   <= ST_HALT;
            tmo_r     <= {TW{1'b0}};
            bus_err_r <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_R: begin
          tmo_r <= {TW{1'b0}};
          case (opclass_s)
            OC_HLT:  state_r <= ST_HALT;
            OC_ILL: begin
              state_r   <= ST_HALT;
              illegal_r <= 1'b1;
            end
            default: state_r <= ST_X;
          endcase
        end
        ST_X: begin
          tmo_r <= {TW{1'b0}};
          case (opclass_s)
            OC_LD, OC_ST:    state_r <= ST_M;
            OC_ALUW, OC_LIL: state_r <= ST_W;
            OC_CMP, OC_JMP:  state_r <= ST_F;
            default: begin
              // The opcode changed after R; treat it as illegal rather than guess.
              state_r   <= ST_HALT;
              illegal_r <= 1'b1;
            end
          endcase
        end
        ST_M: begin
          if (bus.mem_ready) begin
            state_r <= (opclass_s == OC_LD) ? ST_W : ST_F;
            tmo_r   <= {TW{1'b0}};
          end else if (tmo_r == TMO_LAST) begin
            state_r   <= ST_HALT;
            tmo_r     <= {TW{1'b0}};
            bus_err_r <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_W: begin
          tmo_r   <= {TW{1'b0}};
          state_r <= ST_F;
        end
        ST_HALT: tmo_r <= {TW{1'b0}};
        default: begin
          state_r <= ST_IDLE;
          tmo_r   <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign bus.phase       = state_r;
  assign bus.ir_we       = ir_we_s;
  assign bus.mem_re      = mem_re_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.rf_re       = rf_re_s;
  assign bus.alu_en      = alu_en_s;
  assign bus.flag_we     = flag_we_s;
  assign bus.rf_we       = rf_we_s;
  assign bus.pc_we       = pc_we_s;
  assign bus.pc_sel      = pc_sel_s;
  assign bus.halted      = (state_r == ST_HALT);
  assign bus.illegal     = illegal_r;
  assign bus.bus_err     = bus_err_r;
  assign bus.instr_count = count_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed per-cycle vectors queue their expected outputs,
// and negedge monitors pop and compare. A second instance with a 2-bit counter covers saturation.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(16)) bus ();
  phase_sequencer_if #(.CNT_W(2))  bus2 ();

  phase_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut     (.clk(clk), .rst(rst),  .bus(bus));
  phase_sequencer #(.MEM_TIMEOUT(16), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst2), .bus(bus2));

  // Strobe order: {ir_we, mem_re, mem_we, rf_re, alu_en, flag_we, rf_we, pc_we}
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_FETCH = 8'b1100_0000;
  localparam logic [7:0] S_FWAIT = 8'b0100_0000;
  localparam logic [7:0] S_RR    = 8'b0001_0000;
  localparam logic [7:0] S_XALU  = 8'b0000_1100;
  localparam logic [7:0] S_X     = 8'b0000_1000;
  localparam logic [7:0] S_XCMP  = 8'b0000_1101;
  localparam logic [7:0] S_XJMP  = 8'b0000_1001;
  localparam logic [7:0] S_W     = 8'b0000_0011;
  localparam logic [7:0] S_MLD   = 8'b0100_0000;
  localparam logic [7:0] S_MST   = 8'b0010_0001;

  typedef struct packed {
    logic [2:0]  phase;
    logic [7:0]  stb;
    logic        pc_sel;
    logic        halted;
    logic        illegal;
    logic        bus_err;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          id_q[$];
  logic [1:0]  sat_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          vec_id = 0;
  exp_t        e_m;
  exp_t        a_m;
  int          id_m;
  logic [1:0]  es_m;

  // Main scoreboard monitor: one expected vector per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m  = exp_q.pop_front();
      id_m = id_q.pop_front();
      a_m  = {bus.phase,
              {bus.ir_we, bus.mem_re, bus.mem_we, bus.rf_re, bus.alu_en, bus.flag_we, bus.rf_we, bus.pc_we},
              bus.pc_sel, bus.halted, bus.illegal, bus.bus_err, bus.instr_count};
      n_cmp++;
      if (a_m !== e_m) begin
        n_err++;
        $display("FAIL vec%0d: got ph=%0d stb=%b sel=%b halt=%b ill=%b berr=%b cnt=%0d; expected ph=%0d stb=%b sel=%b halt=%b ill=%b berr=%b cnt=%0d",
                 id_m, a_m.phase, a_m.stb, a_m.pc_sel, a_m.halted, a_m.illegal, a_m.bus_err, a_m.count,
                 e_m.phase, e_m.stb, e_m.pc_sel, e_m.halted, e_m.illegal, e_m.bus_err, e_m.count);
      end
    end
  end

  // Saturation monitor: on every retirement of the 2-bit instance, check the pre-increment count.
  always @(negedge clk) begin
    if (bus2.pc_we && (sat_q.size() > 0)) begin
      es_m = sat_q.pop_front();
      n_cmp++;
      if (bus2.instr_count !== es_m) begin
        n_err++;
        $display("FAIL sat_count: got %0d expected %0d", bus2.instr_count, es_m);
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic [7:0] op, input logic rdy,
                      input logic [2:0] ph, input logic [7:0] stb, input logic sel,
                      input logic h, input logic il, input logic be, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    rst           = r;
    bus.start     = st;
    bus.ir_op     = op;
    bus.mem_ready = rdy;
    exp_q.push_back({ph, stb, sel, h, il, be, cnt});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic nrm(input logic [7:0] op, input logic rdy, input logic [2:0] ph,
                     input logic [7:0] stb, input logic sel, input logic [15:0] cnt);
    step(1'b0, 1'b0, op, rdy, ph, stb, sel, 1'b0, 1'b0, 1'b0, cnt);
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    bus.start = 1'b0;
    bus.ir_op = 8'h00;
    bus.mem_ready = 1'b0;
    bus2.start = 1'b0;
    bus2.ir_op = 8'h39;
    bus2.mem_ready = 1'b1;

    // Saturation: 5 CMPs on a 2-bit counter retire with counts 0,1,2,3,3.
    sat_q.push_back(2'd0);
    sat_q.push_back(2'd1);
    sat_q.push_back(2'd2);
    sat_q.push_back(2'd3);
    sat_q.push_back(2'd3);
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int i = 0; i < 40 && sat_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (sat_q.size() != 0) begin
      n_err++;
      $display("FAIL sat_timeout: got %0d retirements pending expected 0", sat_q.size());
    end
    n_cmp++;
    if (bus2.instr_count !== 2'd3) begin
      n_err++;
      $display("FAIL sat_final: got %0d expected 3", bus2.instr_count);
    end
    rst2 = 1'b1;

    // Reset state, idle without start, then start.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 8'h01, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 8'h01, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // ALU-W 01: 4 cycles.
    nrm(8'h01, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd0);
    nrm(8'h01, 1'b1, 3'd1, S_RR,    1'b0, 16'd0);
    nrm(8'h01, 1'b1, 3'd2, S_XALU,  1'b0, 16'd0);
    nrm(8'h01, 1'b1, 3'd4, S_W,     1'b0, 16'd0);
    // LD 8B with mem_ready low for 3 cycles in M.
    nrm(8'h8B, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd1);
    nrm(8'h8B, 1'b1, 3'd1, S_RR,    1'b0, 16'd1);
    nrm(8'h8B, 1'b1, 3'd2, S_X,     1'b0, 16'd1);
    for (int i = 0; i < 3; i++) nrm(8'h8B, 1'b0, 3'd3, S_MLD, 1'b0, 16'd1);
    nrm(8'h8B, 1'b1, 3'd3, S_MLD,   1'b0, 16'd1);
    nrm(8'h8B, 1'b1, 3'd4, S_W,     1'b0, 16'd1);
    // ST 89.
    nrm(8'h89, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd2);
    nrm(8'h89, 1'b1, 3'd1, S_RR,    1'b0, 16'd2);
    nrm(8'h89, 1'b1, 3'd2, S_X,     1'b0, 16'd2);
    nrm(8'h89, 1'b1, 3'd3, S_MST,   1'b0, 16'd2);
    // JMP 90.
    nrm(8'h90, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd3);
    nrm(8'h90, 1'b1, 3'd1, S_RR,    1'b0, 16'd3);
    nrm(8'h90, 1'b1, 3'd2, S_XJMP,  1'b1, 16'd3);
    // CMP 39.
    nrm(8'h39, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd4);
    nrm(8'h39, 1'b1, 3'd1, S_RR,    1'b0, 16'd4);
    nrm(8'h39, 1'b1, 3'd2, S_XCMP,  1'b0, 16'd4);
    // LIL 66.
    nrm(8'h66, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd5);
    nrm(8'h66, 1'b1, 3'd1, S_RR,    1'b0, 16'd5);
    nrm(8'h66, 1'b1, 3'd2, S_X,     1'b0, 16'd5);
    nrm(8'h66, 1'b1, 3'd4, S_W,     1'b0, 16'd5);
    // mem_ready on the 16th fetch cycle: no error.
    for (int i = 0; i < 15; i++) nrm(8'h01, 1'b0, 3'd0, S_FWAIT, 1'b0, 16'd6);
    nrm(8'h01, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd6);
    nrm(8'h01, 1'b1, 3'd1, S_RR,    1'b0, 16'd6);
    nrm(8'h01, 1'b1, 3'd2, S_XALU,  1'b0, 16'd6);
    nrm(8'h01, 1'b1, 3'd4, S_W,     1'b0, 16'd6);
    // 16 fetch cycles without mem_ready: bus error, HALT, start ignored.
    for (int i = 0; i < 16; i++) nrm(8'h01, 1'b0, 3'd0, S_FWAIT, 1'b0, 16'd7);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 8'h01, 1'b0, 3'd6, S_NONE, 1'b0, 1'b1, 1'b0, 1'b1, 16'd7);
    step(1'b1, 1'b0, 8'h01, 1'b0, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 8'h01, 1'b0, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // HLT F4.
    step(1'b0, 1'b1, 8'hF4, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    nrm(8'hF4, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd0);
    nrm(8'hF4, 1'b1, 3'd1, S_RR,    1'b0, 16'd0);
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, 8'hF4, 1'b1, 3'd6, S_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 8'hC3, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // Illegal C3.
    step(1'b0, 1'b1, 8'hC3, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    nrm(8'hC3, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd0);
    nrm(8'hC3, 1'b1, 3'd1, S_RR,    1'b0, 16'd0);
    step(1'b0, 1'b1, 8'hC3, 1'b1, 3'd6, S_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    step(1'b1, 1'b0, 8'h8B, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // Reset asserted during M of an LD: everything drops before the next edge.
    step(1'b0, 1'b1, 8'h8B, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    nrm(8'h8B, 1'b1, 3'd0, S_FETCH, 1'b0, 16'd0);
    nrm(8'h8B, 1'b1, 3'd1, S_RR,    1'b0, 16'd0);
    nrm(8'h8B, 1'b1, 3'd2, S_X,     1'b0, 16'd0);
    nrm(8'h8B, 1'b0, 3'd3, S_MLD,   1'b0, 16'd0);
    step(1'b1, 1'b0, 8'h8B, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 8'h8B, 1'b1, 3'd5, S_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d vectors unchecked expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle control FSM that steps the core through the five phases f (fetch), r (register read), x (execute), m (memory) and w (writeback).
- Reads the latched opcode byte IR[31:24] and drives enable strobes to the IR, register file, ALU/flags, memory port and PC.
- Sits between the memory bus (ready handshake) and the datapath, which the decoder drives.
- Also handles halt, illegal opcodes, memory timeout and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: max cycles to wait for mem_ready in F or M before a bus error.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- ir_op  in  8  IR[31:24] from the IR register; valid from R onward
- mem_ready  in  1  memory access completes this cycle
- phase  out  3  0=f 1=r 2=x 3=m 4=w 5=IDLE 6=HALT
- ir_we  out  1  latch fetched word into IR
- mem_re  out  1  memory read request (fetch or load)
- mem_we  out  1  memory write request (store)
- rf_re  out  1  register file read
- alu_en  out  1  ALU operates
- flag_we  out  1  update flags
- rf_we  out  1  register file write
- pc_we  out  1  update PC; pulses once per retired instruction
- pc_sel  out  1  1 = jump target, 0 = PC+len
- halted  out  1  in HALT state
- illegal  out  1  sticky: halted on an unknown opcode
- bus_err  out  1  sticky: memory timeout
- instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (async, any state): state=IDLE, phase=5, all strobes 0, illegal=0, bus_err=0, instr_count=0, timeout counter=0.
- Strobes are decoded from the state register plus mem_ready/ir_op only; no other state.

Opcode classes (decided in R from ir_op):
- LD 8B
- ST 89
- ALU-W: 01 29 21 09 31 83 F7 C1 (write result and flags)
- LIL 66 (write, no flags)
- CMP 39 (flags only)
- JMP 90
- HLT F4
- Any other value: illegal.

IDLE:
- All strobes 0.
- start=1 -> F next cycle.

F:
- mem_re=1.
- mem_ready=1: ir_we=1 same cycle, go to R.
- Otherwise stay and increment the timeout counter.

R:
- rf_re=1.
- HLT: -> HALT, pc_we=0, not counted.
- Illegal: -> HALT, set illegal.
- Otherwise -> X.

X:
- alu_en=1.
- flag_we=1 for ALU-W and CMP.
- LD/ST -> M.
- ALU-W/LIL -> W.
- CMP: pc_we=1, go to F.
- JMP: pc_we=1, pc_sel=1, go to F.

M:
- LD: mem_re=1. ST: mem_we=1.
- Held until mem_ready=1.
- LD then -> W.
- ST: pc_we=1 in the mem_ready cycle, then -> F.

W:
- rf_we=1, pc_we=1, -> F.

HALT:
- All strobes 0, halted=1.
- start is ignored; only rst exits.

Timeout:
- Counter clears on every phase entry.
- When it reaches MEM_TIMEOUT-1 in F or M with mem_ready=0, the next state is HALT and bus_err is set.
- A mem_ready arriving in that same cycle wins: normal transition, no error.

Counting:
- instr_count increments in every cycle where pc_we=1.
- Saturates at 2^CNT_W-1 (no wrap).

Latency per instruction, with mem_ready immediate:
- CMP/JMP: 3 cycles.
- ALU/LIL: 4 cycles.
- ST: 4 cycles.
- LD: 5 cycles.

Invariants:
- mem_re and mem_we are never high together.
- At most one pc_we per instruction.

Reset mid-M:
- The memory request drops asynchronously.
- No pc_we or rf_we is issued.

Test Plan:
- Reset, start=1, ir_op=01, mem_ready=1 always -> phase sequence 0,1,2,4,0; ir_we in cycle 1; flag_we and rf_we/pc_we in the expected cycles; instr_count=1 after W.
- ir_op=8B with mem_ready low for 3 cycles in M -> mem_re held 4 cycles in M; rf_we exactly once; phase 3->4.
- ir_op=89 -> mem_we in M, pc_we in the mem_ready cycle, no rf_we; ir_op=90 -> pc_we=1 with pc_sel=1 in X, then phase=0.
- ir_op=F4 -> halted=1, phase=6, instr_count unchanged; start pulses ignored; rst returns to IDLE.
- ir_op=C3 (illegal) -> HALT with illegal=1; separately, mem_ready held 0 in F for 16 cycles -> bus_err=1, HALT; mem_ready on cycle 16 exactly -> no error.
- Assert rst during M of an LD -> all outputs at reset values immediately (asynchronous, before the next clk edge); CNT_W=2 with 5 CMPs retired -> instr_count saturates at 3.
